// File: rtl/imm_pkg.sv
// Shared encodings for the ID-stage immediate generator: type codes,
// the extension-mode bit of the select field and the skid-buffer occupancy states.
package imm_pkg;

   localparam logic [2:0] IMM_U   = 3'd0;
   localparam logic [2:0] IMM_J   = 3'd1;
   localparam logic [2:0] IMM_I   = 3'd2;
   localparam logic [2:0] IMM_B   = 3'd3;
   localparam logic [2:0] IMM_S   = 3'd4;
   localparam logic [2:0] IMM_CSR = 3'd5;

   localparam int IMM_UNS_BIT = 3;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } state_t;

endpackage

// File: rtl/imm_extract.sv
// Combinational immediate extraction and extension of a raw instruction word
// to XLEN bits; also used on its own by the ID-stage unit tests.
module imm_extract
   import imm_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [31:0]     inst,
   input  logic [3:0]      imm_sel,
   output logic [XLEN-1:0] imm
);

   logic fill;
   logic unused_opcode;

   assign unused_opcode = ^inst[6:0];

   // The 32-bit value already carries its in-word extension; this only widens to XLEN.
   function automatic logic [XLEN-1:0] widen(input logic [31:0] v, input logic s);
      logic [XLEN-1:0] r;
      r       = {XLEN{s}};
      r[31:0] = v;
      return r;
   endfunction

   always_comb begin
      fill = ~imm_sel[IMM_UNS_BIT] & inst[31];
      imm  = '0;
      case (imm_sel[2:0])
         IMM_U:   imm = widen({inst[31:12], 12'h000}, inst[31]);
         IMM_J:   imm = widen({{11{fill}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}, fill);
         IMM_I:   imm = widen({{20{fill}}, inst[31:20]}, fill);
         IMM_B:   imm = widen({{19{fill}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}, fill);
         IMM_S:   imm = widen({{20{fill}}, inst[31:25], inst[11:7]}, fill);
         IMM_CSR: imm = widen({27'd0, inst[19:15]}, 1'b0);
         default: imm = '0;
      endcase
   end

endmodule

// File: rtl/imm_gen_stage.sv
// Registered immediate generator between IF/ID and ID/EX with a two-entry skid
// buffer; immediates are extended on entry and stored ready to use.
module imm_gen_stage
   import imm_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int TAG_W = 32
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic             FLUSH,
   input  logic             IN_VALID,
   output logic             IN_READY,
   input  logic [31:0]      INST,
   input  logic [3:0]       IMM_SEL,
   input  logic [TAG_W-1:0] IN_TAG,
   output logic             OUT_VALID,
   input  logic             OUT_READY,
   output logic [XLEN-1:0]  OUT_IMM,
   output logic [TAG_W-1:0] OUT_TAG
);

   state_t state_q, state_d;

   logic [XLEN-1:0]  ext_imm_p0;
   logic [XLEN-1:0]  head_imm_p1, skid_imm_p1;
   logic [TAG_W-1:0] head_tag_p1, skid_tag_p1;

   logic accept, pop;
   logic head_load_in, head_load_skid, skid_load;

   // Stage p0: extraction from the raw instruction at the input
   imm_extract #(.XLEN(XLEN)) u_extract (
      .inst    (INST),
      .imm_sel (IMM_SEL),
      .imm     (ext_imm_p0)
   );

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) state_q <= EMPTY;
      else        state_q <= state_d;
   end

   // IN_READY depends only on the registered occupancy, gated low while in reset.
   always_comb begin
      state_d        = state_q;
      head_load_in   = 1'b0;
      head_load_skid = 1'b0;
      skid_load      = 1'b0;
      IN_READY       = RESET && (state_q != FULL);
      OUT_VALID      = (state_q != EMPTY);
      accept         = IN_VALID && IN_READY;
      pop            = OUT_VALID && OUT_READY;

      case (state_q)
         EMPTY: begin
            if (accept) begin
               head_load_in = 1'b1;
               state_d      = ONE;
            end
         end
         ONE: begin
            if (accept && pop) begin
               head_load_in = 1'b1;
            end else if (accept) begin
               skid_load = 1'b1;
               state_d   = FULL;
            end else if (pop) begin
               state_d = EMPTY;
            end
         end
         FULL: begin
            if (pop) begin
               head_load_skid = 1'b1;
               state_d        = ONE;
            end
         end
         default: state_d = EMPTY;
      endcase

      if (FLUSH) begin
         state_d        = EMPTY;
         head_load_in   = 1'b0;
         head_load_skid = 1'b0;
         skid_load      = 1'b0;
      end
   end

   // Stage p1: head (drives OUT_*) and skid entries
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         head_imm_p1 <= '0;
         head_tag_p1 <= '0;
         skid_imm_p1 <= '0;
         skid_tag_p1 <= '0;
      end else begin
         if (head_load_in) begin
            head_imm_p1 <= ext_imm_p0;
            head_tag_p1 <= IN_TAG;
         end else if (head_load_skid) begin
            head_imm_p1 <= skid_imm_p1;
            head_tag_p1 <= skid_tag_p1;
         end
         if (skid_load) begin
            skid_imm_p1 <= ext_imm_p0;
            skid_tag_p1 <= IN_TAG;
         end
      end
   end

   assign OUT_IMM = head_imm_p1;
   assign OUT_TAG = head_tag_p1;

endmodule
